// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for one elastic pipeline boundary: upstream in_* side and downstream out_* side.
// master = the surrounding pipeline (drives in_*, out_ready); slave = the stage register itself.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, flush-to-bubble and optional
// saturating stall/bubble statistics (enabled by defining PIPE_STAT_EN).
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_buf_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mainData_q, mainData_d;
  logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;
  logic [DATA_W-1:0] skidData_q, skidData_d;
  logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
  logic              mainValid;
  logic              accept;
  logic              pop;

  // in_ready is a pure decode of registered state so out_ready never reaches upstream.
  assign mainValid     = (state_q != EMPTY);
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = mainValid;
  assign bus.out_ctrl  = mainValid ? mainCtrl_q : '0;
  assign bus.out_data  = mainData_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    mainData_d = mainData_q;
    mainCtrl_d = mainCtrl_q;
    skidData_d = skidData_q;
    skidCtrl_d = skidCtrl_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          mainData_d = bus.in_data;
          mainCtrl_d = bus.in_ctrl;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_d    = FULL;
          skidData_d = bus.in_data;
          skidCtrl_d = bus.in_ctrl;
        end else if (accept && pop) begin
          mainData_d = bus.in_data;
          mainCtrl_d = bus.in_ctrl;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d    = ONE;
          mainData_d = skidData_q;
          mainCtrl_d = skidCtrl_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush discards everything, including a same-cycle accept; out_data keeps its old value.
    if (flush) begin
      state_d    = EMPTY;
      mainData_d = mainData_q;
      mainCtrl_d = mainCtrl_q;
      skidData_d = skidData_q;
      skidCtrl_d = skidCtrl_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      mainData_q <= '0;
      mainCtrl_q <= '0;
      skidData_q <= '0;
      skidCtrl_q <= '0;
    end else begin
      state_q    <= state_d;
      mainData_q <= mainData_d;
      mainCtrl_q <= mainCtrl_d;
      skidData_q <= skidData_d;
      skidCtrl_q <= skidCtrl_d;
    end
  end

`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;

  // Saturating counters; flush deliberately leaves them alone.
  always_comb begin
    stallCnt_d  = stallCnt_q;
    bubbleCnt_d = bubbleCnt_q;
    if (bus.out_valid && !bus.out_ready && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
    if (bus.out_ready && !bus.out_valid && (bubbleCnt_q != '1)) begin
      bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
    end else begin
      stallCnt_q  <= stallCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign stall_cnt  = stallCnt_q;
  assign bubble_cnt = bubbleCnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
